fadd_pipe: RTL

- Parametrised, pipelined IEEE-754 binary floating-point adder/subtractor.
- Successor to the single-precision combinational fadd. Generalised in exponent and mantissa width.
- Adds a per-operation subtract mode, full round-to-nearest-even, and a 3-stage valid/ready pipeline with backpressure.
- Sits between the operand issue logic and the FP result writeback in the FPU datapath.

---
 rtl/fadd_pipe.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/fadd_pipe.sv
// fadd_pipe: parametrised 3-stage IEEE-754 adder/subtractor with valid/ready
// flow control. Stage 1 classifies and aligns, stage 2 adds, stage 3
// normalises, rounds to nearest-even and drives the output register.
module fadd_pipe #(
    parameter  int unsigned EXP_W = 8,
    parameter  int unsigned MAN_W = 23,
    localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] res,
    output logic         ovf,
    output logic         inv
);

    // SW: hidden bit + fraction + guard/round/sticky
    localparam int unsigned SW  = MAN_W + 4;
    localparam int unsigned EW  = EXP_W + 1;
    localparam int unsigned LZW = $clog2(SW + 1);
    localparam int unsigned SHW = (LZW > EW) ? LZW : EW;

    // ---------------- flow control ----------------
    logic r1_valid, r2_valid, r3_valid;
    logic w_ld1, w_ld2, w_ld3;

    assign w_ld3    = !r3_valid || out_ready;
    assign w_ld2    = !r2_valid || w_ld3;
    assign w_ld1    = !r1_valid || w_ld2;
    assign in_ready = w_ld1;

    // ---------------- stage 1: classify / align ----------------
    logic             w_bs;
    logic [EXP_W-1:0] w_ea, w_eb, w_xa, w_xb, w_exp_l, w_exp_s, w_diff;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic [MAN_W:0]   w_sig_a, w_sig_b, w_sig_l, w_sig_s;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic             w_a_big, w_sign_l;
    logic [SW-1:0]    w_sm_raw, w_sm_shf, w_sm_mask, w_sm_ext;
    logic             w_sm_lost;
    logic             w_spec, w_spec_inv;
    logic [W-1:0]     w_spec_res;

    assign w_bs     = b[W-1] ^ sub;
    assign w_ea     = a[W-2:MAN_W];
    assign w_eb     = b[W-2:MAN_W];
    assign w_fa     = a[MAN_W-1:0];
    assign w_fb     = b[MAN_W-1:0];
    assign w_a_nan  = (&w_ea) && (|w_fa);
    assign w_b_nan  = (&w_eb) && (|w_fb);
    assign w_a_inf  = (&w_ea) && !(|w_fa);
    assign w_b_inf  = (&w_eb) && !(|w_fb);
    assign w_a_zero = !(|w_ea) && !(|w_fa);
    assign w_b_zero = !(|w_eb) && !(|w_fb);

    // subnormals: hidden bit 0, effective exponent 1
    assign w_sig_a  = {|w_ea, w_fa};
    assign w_sig_b  = {|w_eb, w_fb};
    assign w_xa     = (|w_ea) ? w_ea : EXP_W'(1);
    assign w_xb     = (|w_eb) ? w_eb : EXP_W'(1);

    // equal magnitudes keep a as the large operand
    assign w_a_big  = a[W-2:0] >= b[W-2:0];
    assign w_sign_l = w_a_big ? a[W-1]  : w_bs;
    assign w_exp_l  = w_a_big ? w_xa    : w_xb;
    assign w_exp_s  = w_a_big ? w_xb    : w_xa;
    assign w_sig_l  = w_a_big ? w_sig_a : w_sig_b;
    assign w_sig_s  = w_a_big ? w_sig_b : w_sig_a;
    assign w_diff   = w_exp_l - w_exp_s;

    assign w_sm_raw  = {w_sig_s, 3'b000};
    assign w_sm_shf  = w_sm_raw >> w_diff;
    assign w_sm_mask = (SW'(1) << w_diff) - SW'(1);
    assign w_sm_lost = |(w_sm_raw & w_sm_mask);
    assign w_sm_ext  = (32'(w_diff) >= 32'(MAN_W + 3))
                     ? {{(SW-1){1'b0}}, |w_sig_s}
                     : {w_sm_shf[SW-1:1], w_sm_shf[0] | w_sm_lost};

    // special-case result selection in priority order
    always_comb begin
        w_spec     = 1'b0;
        w_spec_inv = 1'b0;
        w_spec_res = '0;
        if (w_b_nan) begin
            w_spec     = 1'b1;
            w_spec_inv = 1'b1;
            w_spec_res = {b[W-1:MAN_W], 1'b1, b[MAN_W-2:0]};
        end else if (w_a_nan) begin
            w_spec     = 1'b1;
            w_spec_inv = 1'b1;
            w_spec_res = {a[W-1:MAN_W], 1'b1, a[MAN_W-2:0]};
        end else if (w_a_inf && w_b_inf && (a[W-1] != w_bs)) begin
            w_spec     = 1'b1;
            w_spec_inv = 1'b1;
            w_spec_res = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (w_a_inf) begin
            w_spec     = 1'b1;
            w_spec_res = a;
        end else if (w_b_inf) begin
            w_spec     = 1'b1;
            w_spec_res = {w_bs, b[W-2:0]};
        end else if (w_a_zero && w_b_zero) begin
            w_spec     = 1'b1;
            w_spec_res = {a[W-1] & w_bs, {(W-1){1'b0}}};
        end
    end

    logic             r1_spec, r1_spec_inv, r1_sign, r1_sub;
    logic [W-1:0]     r1_spec_res;
    logic [EXP_W-1:0] r1_exp;
    logic [SW-1:0]    r1_big, r1_small;

    // stage 1 register: capture aligned operands on input transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
        end else if (w_ld1) begin
            r1_valid <= in_valid;
            if (in_valid) begin
                r1_spec     <= w_spec;
                r1_spec_inv <= w_spec_inv;
                r1_spec_res <= w_spec_res;
                r1_sign     <= w_sign_l;
                r1_sub      <= a[W-1] ^ w_bs;
                r1_exp      <= w_exp_l;
                r1_big      <= {w_sig_l, 3'b000};
                r1_small    <= w_sm_ext;
            end
        end
    end

    // ---------------- stage 2: add / subtract ----------------
    logic [SW:0] w_sum;

    assign w_sum = r1_sub ? ({1'b0, r1_big} - {1'b0, r1_small})
                          : ({1'b0, r1_big} + {1'b0, r1_small});

    logic             r2_spec, r2_spec_inv, r2_sign;
    logic [W-1:0]     r2_spec_res;
    logic [EXP_W-1:0] r2_exp;
    logic [SW:0]      r2_sum;

    // stage 2 register: exact cancellation yields +0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r2_valid <= 1'b0;
        end else if (w_ld2) begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_spec     <= r1_spec;
                r2_spec_inv <= r1_spec_inv;
                r2_spec_res <= r1_spec_res;
                r2_sign     <= (r1_sub && (w_sum == '0)) ? 1'b0 : r1_sign;
                r2_exp      <= r1_exp;
                r2_sum      <= w_sum;
            end
        end
    end

    // ---------------- stage 3: normalise / round ----------------
    logic [SW-1:0]  w_v, w_norm;
    logic [LZW-1:0] w_lz;
    logic [SHW-1:0] w_lzx, w_emax1, w_sh;
    logic [EW-1:0]  w_ne, w_en, w_ef;
    logic           w_rnd;
    logic [MAN_W+1:0] w_mr;
    logic [MAN_W-1:0] w_frac;
    logic [W-1:0]   w_res3;
    logic           w_ovf3, w_inv3;

    assign w_v = r2_sum[SW-1:0];

    // leading-zero count of the non-carry sum
    always_comb begin
        w_lz = LZW'(SW);
        for (int unsigned i = 0; i < SW; i++) begin
            if (w_v[i]) w_lz = LZW'(SW - 1 - i);
        end
    end

    assign w_lzx   = SHW'(w_lz);
    assign w_emax1 = SHW'(r2_exp) - SHW'(1);
    assign w_sh    = (w_lzx < w_emax1) ? w_lzx : w_emax1;

    // normalise, round to nearest-even, detect overflow, apply specials
    always_comb begin
        w_norm = '0;
        w_ne   = '0;
        w_ef   = '0;
        w_frac = '0;
        w_res3 = '0;
        w_ovf3 = 1'b0;
        w_inv3 = 1'b0;
        if (r2_sum[SW]) begin
            w_norm = {r2_sum[SW:2], r2_sum[1] | r2_sum[0]};
            w_ne   = EW'(r2_exp) + EW'(1);
        end else begin
            w_norm = w_v << w_sh;
            w_ne   = EW'(r2_exp) - EW'(w_sh);
        end
        w_en  = w_norm[SW-1] ? w_ne : '0;
        w_rnd = w_norm[2] && (w_norm[1] || w_norm[0] || w_norm[3]);
        w_mr  = {1'b0, w_norm[SW-1:3]} + (MAN_W+2)'(w_rnd);
        if (w_mr[MAN_W+1]) begin
            w_ef   = w_en + EW'(1);
            w_frac = w_mr[MAN_W:1];
        end else if (w_mr[MAN_W] && (w_en == '0)) begin
            w_ef   = EW'(1);
            w_frac = w_mr[MAN_W-1:0];
        end else begin
            w_ef   = w_en;
            w_frac = w_mr[MAN_W-1:0];
        end
        if (w_ef >= EW'({EXP_W{1'b1}})) begin
            w_ovf3 = 1'b1;
            w_res3 = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            w_res3 = {r2_sign, w_ef[EXP_W-1:0], w_frac};
        end
        if (r2_spec) begin
            w_res3 = r2_spec_res;
            w_ovf3 = 1'b0;
            w_inv3 = r2_spec_inv;
        end
    end

    logic [W-1:0] r3_res;
    logic         r3_ovf, r3_inv;

    // output register: holds its result while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r3_valid <= 1'b0;
            r3_res   <= '0;
            r3_ovf   <= 1'b0;
            r3_inv   <= 1'b0;
        end else if (w_ld3) begin
            r3_valid <= r2_valid;
            if (r2_valid) begin
                r3_res <= w_res3;
                r3_ovf <= w_ovf3;
                r3_inv <= w_inv3;
            end
        end
    end

    assign out_valid = r3_valid;
    assign res       = r3_res;
    assign ovf       = r3_ovf;
    assign inv       = r3_inv;

endmodule
